// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter onto one shared slave port.
// The owner holds the bus until it drops cyc; a watchdog ends a stalled beat with err.
module wb_rr_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  // Handshake: a beat completes when the owner's stb is high and the slave
  // returns ack (data valid) or err, or the watchdog expires; cyc frames the tenure.
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t          state;
  logic            last;
  logic [TO_W-1:0] wdog;

  logic            own_cyc, own_stb, own_we;
  logic [3:0]      own_sel;
  logic [31:0]     own_adr, own_dat;
  logic            wdog_err;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = 4'd0;
    own_adr = 32'd0;
    own_dat = 32'd0;
    case (state)
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_sel = m1_sel_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A real ack in the expiry cycle takes precedence over the watchdog.
  assign wdog_err = own_stb & ~s_ack_i & ~s_err_i & (wdog == TO_W'(TIMEOUT - 1));

  assign s_cyc_o  = own_cyc;
  assign s_stb_o  = own_stb & ~wdog_err;
  assign s_we_o   = own_we;
  assign s_sel_o  = own_sel;
  assign s_adr_o  = own_adr;
  assign s_dat_o  = own_dat;

  assign gnt_o    = {state == GNT1, state == GNT0};
  assign m0_ack_o = (state == GNT0) & s_ack_i;
  assign m1_ack_o = (state == GNT1) & s_ack_i;
  assign m0_err_o = (state == GNT0) & (s_err_i | wdog_err);
  assign m1_err_o = (state == GNT1) & (s_err_i | wdog_err);
  assign m0_dat_o = (state == GNT0) ? s_dat_i : 32'd0;
  assign m1_dat_o = (state == GNT1) ? s_dat_i : 32'd0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      wdog <= '0;
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= last ? GNT0 : GNT1;
          else if (m0_cyc_i)        state <= GNT0;
          else if (m1_cyc_i)        state <= GNT1;
        end
        GNT0, GNT1: begin
          if (!own_cyc) begin
            state <= IDLE;
            last  <= (state == GNT1);
          end else if (own_stb && !s_ack_i && !s_err_i && !wdog_err) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Table-driven bench for wb_rr_arbiter: per-cycle vectors feed an expected-result
// queue that is compared against the observed bus outputs each cycle.
module tb_wb_rr_arbiter;

  localparam int W = 141;
  localparam logic [31:0] SDAT   = 32'hDEADBEEF;
  localparam logic [31:0] M0_ADR = 32'h0000_0010;
  localparam logic [31:0] M1_ADR = 32'h0000_0020;
  localparam logic [31:0] M0_DAT = 32'h1111_0000;
  localparam logic [31:0] M1_DAT = 32'h2222_5555;
  localparam logic [3:0]  M0_SEL = 4'b1111;
  localparam logic [3:0]  M1_SEL = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  gnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic rst, c0, s0, w0, c1, s1, w1, ack, err;
    logic [1:0] gnt;
    logic a0, e0, a1, e1, stb;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT(8), .TO_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(gnt)
  );

  function automatic vec_t mk(input logic r, c0, s0, w0, c1, s1, w1, ack, err,
                              input logic [1:0] g, input logic a0, e0, a1, e1, stb);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.w0 = w0; v.c1 = c1; v.s1 = s1; v.w1 = w1;
    v.ack = ack; v.err = err; v.gnt = g; v.a0 = a0; v.e0 = e0; v.a1 = a1; v.e1 = e1;
    v.stb = stb;
    return v;
  endfunction

  // Slave-side fields follow whichever master the vector says owns the bus.
  function automatic logic [W-1:0] expect_of(input vec_t v);
    logic o0, o1, cyc, we;
    logic [3:0] sel;
    logic [31:0] adr, wd;
    o0 = (v.gnt == 2'b01);
    o1 = (v.gnt == 2'b10);
    cyc = o0 ? v.c0 : (o1 ? v.c1 : 1'b0);
    we  = o0 ? v.w0 : (o1 ? v.w1 : 1'b0);
    sel = o0 ? M0_SEL : (o1 ? M1_SEL : 4'd0);
    adr = o0 ? M0_ADR : (o1 ? M1_ADR : 32'd0);
    wd  = o0 ? M0_DAT : (o1 ? M1_DAT : 32'd0);
    return {v.gnt, v.a0, v.e0, v.a1, v.e1, cyc, v.stb, we, sel, adr, wd,
            o0 ? SDAT : 32'd0, o1 ? SDAT : 32'd0};
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [W-1:0] act, exp_v;
    @(negedge clk);
    rst = v.rst; m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.w0;
    m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.w1; s_ack = v.ack; s_err = v.err;
    exp_q.push_back(expect_of(v));
    #2;
    act = {gnt, m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_sel, s_adr,
           s_wdat, m0_rdat, m1_rdat};
    exp_v = exp_q.pop_front();
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} = '0;
    m0_sel = M0_SEL; m1_sel = M1_SEL;
    m0_adr = M0_ADR; m1_adr = M1_ADR;
    m0_dat = M0_DAT; m1_dat = M1_DAT;
    s_rdat = SDAT;
    repeat (2) @(posedge clk);

    // rst c0 s0 w0 c1 s1 w1 ack err | gnt a0 e0 a1 e1 stb
    // m0 read; ack while IDLE must be ignored
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,1,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 2'b01,0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0,0,0,0,1,0, 2'b01,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    // tie after reset, alternation, drop-and-raise in the same cycle
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 2'b10,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    // m1 burst of 4 writes while m0 keeps requesting
    tbl.push_back(mk(0,1,1,0,1,1,1,0,0, 2'b00,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,1,1,0,1,1,1,1,0, 2'b10,0,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 2'b10,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 2'b01,0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0,0,0,0,1,0, 2'b01,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    // reset in the middle of an m1 beat, then a tie must go to m0
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0, 2'b10,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,1,0,0,0, 2'b10,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));
    // slave err goes to the owner only; err while IDLE is dropped
    tbl.push_back(mk(0,0,0,0,1,1,0,0,1, 2'b00,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0,1, 2'b10,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b10,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // watchdog with TIMEOUT=8: err on the 8th stalled cycle, stb suppressed, grant kept
    apply(mk(0,1,1,0,0,0,0,0,0, 2'b00,0,0,0,0,0), "wd_req");
    for (int k = 1; k <= 8; k++)
      apply(mk(0,1,1,0,0,0,0,0,0, 2'b01,0,(k == 8),0,0,(k != 8)), $sformatf("wd_stall%0d", k));
    for (int k = 1; k <= 3; k++)
      apply(mk(0,1,1,0,0,0,0,0,0, 2'b01,0,0,0,0,1), $sformatf("wd_restart%0d", k));
    apply(mk(0,1,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0), "wd_stb_low");
    // ack arriving exactly at expiry beats the watchdog
    for (int k = 1; k <= 8; k++)
      apply(mk(0,1,1,0,0,0,0,(k == 8),0, 2'b01,(k == 8),0,0,0,1), $sformatf("wd_ack%0d", k));
    apply(mk(0,0,0,0,0,0,0,0,0, 2'b01,0,0,0,0,0), "wd_drop");
    apply(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0), "wd_idle");

    // randomised single-master reads; the grant must land one cycle later
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 5);
      apply(mk(0,0,0,0,1,1,0,0,0, 2'b00,0,0,0,0,0), "rnd_req");
      for (int k = 0; k < n; k++)
        apply(mk(0,0,0,0,1,1,0,(k == n - 1),0, 2'b10,0,0,(k == n - 1),0,1), "rnd_beat");
      apply(mk(0,0,0,0,0,0,0,0,0, 2'b10,0,0,0,0,0), "rnd_drop");
      apply(mk(0,0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0), "rnd_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
